// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and lock supervisor: drives the PLL reset, qualifies lock,
// releases per-domain reset requests in index order and handles loss/timeout.
module pll_lock_supervisor #(
  parameter int NUM_CLOCKS       = 3,
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 65536,
  parameter int STABLE_CYCLES    = 1024,
  parameter int STAGE_DELAY      = 64,
  parameter int MAX_RETRIES      = 3,
  parameter int CNT_W            = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  retry,
  output logic                  pll_rst,
  output logic [NUM_CLOCKS-1:0] rst_req,
  output logic                  ready,
  output logic                  error,
  output logic [CNT_W-1:0]      lock_loss_count
);

  function automatic int max2(input int a, input int b);
    if (a > b) begin
      max2 = a;
    end else begin
      max2 = b;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  localparam int MAX_CYC = max2(max2(RST_PULSE_CYCLES, LOCK_TIMEOUT),
                                max2(STABLE_CYCLES, STAGE_DELAY));
  localparam int TW = $clog2(MAX_CYC) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] STAGE_LAST  = TW'(STAGE_DELAY - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  logic [1:0]    sync_r;
  logic          lock_s;
  logic [2:0]    state_r;
  logic [TW-1:0] cnt_r;
  logic [RW-1:0] retries_r;
  logic [RW-1:0] retries_next;

  assign lock_s       = sync_r[1];
  assign retries_next = retries_r + RW'(1);

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], locked};
    end
  end

  // Supervisor state machine; all outputs are registered here.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r         <= S_PLL_RST;
      cnt_r           <= '0;
      retries_r       <= '0;
      pll_rst         <= 1'b1;
      rst_req         <= '1;
      ready           <= 1'b0;
      error           <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      case (state_r)
        S_PLL_RST: begin
          rst_req <= '1;
          ready   <= 1'b0;
          if (cnt_r == RST_LAST) begin
            state_r <= S_WAIT_LOCK;
            cnt_r   <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + TW'(1);
            pll_rst <= 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          // Lock wins over a coincident timeout.
          if (lock_s) begin
            state_r <= S_STABLE;
            cnt_r   <= '0;
          end else if (cnt_r == TO_LAST) begin
            cnt_r     <= '0;
            retries_r <= retries_next;
            pll_rst   <= 1'b1;
            if (retries_next == RETRY_MAX) begin
              state_r <= S_FAULT;
              error   <= 1'b1;
            end else begin
              state_r <= S_PLL_RST;
            end
          end else begin
            cnt_r <= cnt_r + TW'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_r <= S_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == STABLE_LAST) begin
            state_r <= S_RELEASE;
            cnt_r   <= '0;
            rst_req <= rst_req << 1;
          end else begin
            cnt_r <= cnt_r + TW'(1);
          end
        end
        S_RELEASE: begin
          if (!lock_s) begin
            state_r         <= S_PLL_RST;
            cnt_r           <= '0;
            pll_rst         <= 1'b1;
            rst_req         <= '1;
            ready           <= 1'b0;
            lock_loss_count <= sat_inc(lock_loss_count);
          end else if (cnt_r == STAGE_LAST) begin
            // Shifting in zeros from bit 0 releases domains in index order.
            cnt_r <= '0;
            if (rst_req == '0) begin
              state_r   <= S_RUN;
              ready     <= 1'b1;
              retries_r <= '0;
            end else begin
              rst_req <= rst_req << 1;
            end
          end else begin
            cnt_r <= cnt_r + TW'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_r         <= S_PLL_RST;
            cnt_r           <= '0;
            pll_rst         <= 1'b1;
            rst_req         <= '1;
            ready           <= 1'b0;
            lock_loss_count <= sat_inc(lock_loss_count);
          end else begin
            state_r <= S_RUN;
          end
        end
        S_FAULT: begin
          pll_rst <= 1'b1;
          rst_req <= '1;
          ready   <= 1'b0;
          if (retry) begin
            state_r   <= S_PLL_RST;
            cnt_r     <= '0;
            retries_r <= '0;
            error     <= 1'b0;
          end else begin
            error <= 1'b1;
          end
        end
        default: begin
          state_r <= S_PLL_RST;
          cnt_r   <= '0;
          pll_rst <= 1'b1;
          rst_req <= '1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor; edge numbers count
// refclk rising edges after the most recent rst release.
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst;
  logic       locked;
  logic       retry;
  logic       pll_rst;
  logic [2:0] rst_req;
  logic       ready;
  logic       error;
  logic [1:0] lock_loss_count;

  int tests  = 0;
  int failed = 0;
  int e      = 0;

  pll_lock_supervisor #(
    .NUM_CLOCKS(3), .RST_PULSE_CYCLES(4), .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8), .STAGE_DELAY(2), .MAX_RETRIES(2), .CNT_W(2)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .retry(retry),
    .pll_rst(pll_rst), .rst_req(rst_req), .ready(ready), .error(error),
    .lock_loss_count(lock_loss_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    e++;
  endtask

  task automatic go(input int n);
    while (e < n) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_rst_req"}, 32'(rst_req), 32'h7);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_count"}, 32'(lock_loss_count), 32'd0);
  endtask

  task automatic release_rst();
    tick();
    tick();
    rst = 1'b0;
    e   = 0;
  endtask

  initial begin
    int k;
    int r;
    int falls;
    int plen;
    int rise_e;
    logic prev;

    rst = 1'b1; locked = 1'b0; retry = 1'b0;
    #2;
    chk_reset("por");
    release_rst();

    // Nominal bring-up
    go(3);  chk("nom_pll_rst_e3", 32'(pll_rst), 32'd1);
    go(4);  chk("nom_pll_rst_e4", 32'(pll_rst), 32'd0);
    go(9);  locked = 1'b1;
    go(19); chk("nom_req_e19", 32'(rst_req), 32'h7);
    go(20); chk("nom_req_e20", 32'(rst_req), 32'h6);
    go(21); chk("nom_req_e21", 32'(rst_req), 32'h6);
    go(22); chk("nom_req_e22", 32'(rst_req), 32'h4);
    go(24); chk("nom_req_e24", 32'(rst_req), 32'h0);
    go(25); chk("nom_ready_e25", 32'(ready), 32'd0);
    go(26); chk("nom_ready_e26", 32'(ready), 32'd1);
    chk("nom_error", 32'(error), 32'd0);

    // Lock loss in RUN, then full staged re-release
    go(30); locked = 1'b0;
    go(32); chk("loss_ready_e32", 32'(ready), 32'd1);
    go(33);
    chk("loss_req", 32'(rst_req), 32'h7);
    chk("loss_ready", 32'(ready), 32'd0);
    chk("loss_pll_rst", 32'(pll_rst), 32'd1);
    chk("loss_count1", 32'(lock_loss_count), 32'd1);
    locked = 1'b1;
    go(36); chk("rl_pll_rst_e36", 32'(pll_rst), 32'd1);
    go(37); chk("rl_pll_rst_e37", 32'(pll_rst), 32'd0);
    go(45); chk("rl_req_e45", 32'(rst_req), 32'h7);
    go(46); chk("rl_req_e46", 32'(rst_req), 32'h6);
    go(48); chk("rl_req_e48", 32'(rst_req), 32'h4);
    go(50); chk("rl_req_e50", 32'(rst_req), 32'h0);
    go(52); chk("rl_ready_e52", 32'(ready), 32'd1);

    // Second loss, then reset between rst_req[0] and rst_req[1] release
    go(55); locked = 1'b0;
    go(58);
    chk("loss_count2", 32'(lock_loss_count), 32'd2);
    locked = 1'b1;
    go(71); chk("mid_req_e71", 32'(rst_req), 32'h6);
    go(72);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    locked = 1'b0;
    release_rst();

    // Chatter: one low cycle sampled at edge 15 restarts qualification
    go(9);  locked = 1'b1;
    go(14); locked = 1'b0;
    go(15); locked = 1'b1;
    go(20); chk("chat_req_e20", 32'(rst_req), 32'h7);
    go(25); chk("chat_req_e25", 32'(rst_req), 32'h7);
    go(26); chk("chat_req_e26", 32'(rst_req), 32'h6);
    go(31); chk("chat_ready_e31", 32'(ready), 32'd0);
    go(32); chk("chat_ready_e32", 32'(ready), 32'd1);

    // Saturation: five losses with a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      locked = 1'b0;
      k = 0;
      while (!(rst_req == 3'b111 && pll_rst == 1'b1) && k < 6) begin
        tick();
        k++;
      end
      chk("sat_react_within3", 32'(k <= 3), 32'd1);
      chk("sat_count", 32'(lock_loss_count), (i < 3) ? 32'(i + 1) : 32'd3);
      locked = 1'b1;
      k = 0;
      while (rst_req == 3'b111 && k < 100) begin
        tick();
        k++;
      end
      chk("sat_relock", 32'(k < 100), 32'd1);
    end

    // Timeout and fault with locked held low
    locked = 1'b0;
    k = 0;
    while (pll_rst != 1'b1 && k < 6) begin
      tick();
      k++;
    end
    chk("to_loss_pll_rst", 32'(pll_rst), 32'd1);
    falls = 0; plen = 0; rise_e = -1; prev = pll_rst;
    for (int j = 0; j < 300 && error !== 1'b1; j++) begin
      tick();
      if (prev && !pll_rst) begin
        falls++;
        if (rise_e >= 0) plen = e - rise_e;
      end
      if (!prev && pll_rst) rise_e = e;
      prev = pll_rst;
    end
    chk("fault_error", 32'(error), 32'd1);
    chk("fault_pulses", 32'(falls), 32'd2);
    chk("fault_pulse_len", 32'(plen), 32'd4);
    chk("fault_pll_rst", 32'(pll_rst), 32'd1);
    chk("fault_req", 32'(rst_req), 32'h7);
    chk("fault_ready", 32'(ready), 32'd0);
    go(e + 3);
    chk("fault_sticky", 32'(error), 32'd1);
    retry = 1'b1;
    tick();
    retry = 1'b0;
    r = e;
    chk("retry_error", 32'(error), 32'd0);
    chk("retry_pll_rst", 32'(pll_rst), 32'd1);
    go(r + 3); chk("retry_pll_rst_r3", 32'(pll_rst), 32'd1);
    go(r + 4); chk("retry_pll_rst_r4", 32'(pll_rst), 32'd0);
    chk("retry_count_kept", 32'(lock_loss_count), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
